// File: rtl/ps2_host_cmd_ctrl.sv
// ps2_host_cmd_ctrl: host-to-keyboard PS/2 command sequencer.
//   Takes a command (opcode plus optional argument byte). Runs inhibit and request-to-send.
//   Shifts each byte out on the device clock, then checks the line ack.
//   Owns the receive path until the device answers FA (ack) or FE (resend).
//   Retries FE up to MAX_RETRY times, and reports done or err with a held err_code.
// Optional feature: define PS2_BAT_WAIT_EN so that an acked FF (reset) also waits for
//   the AA self-test byte before completing.
// Ports:
//   clk, rst                  system clock, asynchronous active-high reset
//   ps2_clk_i, ps2_data_i     raw open-drain PS/2 lines (asynchronous)
//   ps2_clk_oe, ps2_data_oe   1 = pull the line low, 0 = release
//   cmd_valid/cmd_ready       command handshake; cmd_op, cmd_has_arg, cmd_arg payload
//   rx_valid/rx_byte/rx_err   byte strobe from the scancode receiver
//   rx_owned                  1 while this block consumes received bytes
//   done, err                 one-cycle completion/abort pulses
//   err_code                  01 timeout, 10 no line-ack, 11 retries exhausted/unexpected byte
module ps2_host_cmd_ctrl #(
    parameter int unsigned INHIBIT_CYC  = 5000,
    parameter int unsigned START_TO_CYC = 750000,
    parameter int unsigned BIT_TO_CYC   = 6000,
    parameter int unsigned RESP_TO_CYC  = 1000000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned BAT_TO_CYC   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_op,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_err,
    output logic       rx_owned,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned TO_A    = (START_TO_CYC > BIT_TO_CYC) ? START_TO_CYC : BIT_TO_CYC;
    localparam int unsigned TO_B    = (RESP_TO_CYC > BAT_TO_CYC) ? RESP_TO_CYC : BAT_TO_CYC;
    localparam int unsigned TO_C    = (TO_A > TO_B) ? TO_A : TO_B;
    localparam int unsigned MAX_TO  = (TO_C > INHIBIT_CYC) ? TO_C : INHIBIT_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_TO + 1);
    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;
`ifdef PS2_BAT_WAIT_EN
    localparam logic [7:0] BYTE_RESET  = 8'hFF;
    localparam logic [7:0] BYTE_BAT_OK = 8'hAA;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_TX, S_LACK, S_WAIT_IDLE, S_RESP, S_BAT, S_DONE, S_ERR
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [3:0]           bit_q;
    logic [RETRY_W-1:0]   retry_q;
    logic [7:0]           op_q;
    logic [7:0]           arg_q;
    logic                 has_arg_q;
    logic                 arg_phase_q;
    logic [7:0]           cur_q;
    logic                 clk_oe_q;
    logic                 data_oe_q;
    logic                 cmd_ready_q;
    logic                 rx_owned_q;
    logic                 done_q;
    logic                 err_q;
    logic [1:0]           err_code_q;

    // Line synchronisers; the clock keeps one extra stage for falling-edge detection.
    logic [2:0] clk_sync_q;
    logic [1:0] data_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    logic clk_s, data_s, clk_fall;
    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];

    logic rx_ack_c, rx_resend_c, bit_to_c;
    assign rx_ack_c    = !rx_err && (rx_byte == BYTE_ACK);
    assign rx_resend_c = rx_err || (rx_byte == BYTE_RESEND);
    assign bit_to_c    = (cnt_q == CNT_W'(BIT_TO_CYC - 1));

    // Abort decode: every path into ERR, with the code it reports.
    logic       abort_c;
    logic [1:0] abort_code_c;

    always_comb begin
        abort_c      = 1'b0;
        abort_code_c = 2'b01;
        case (state_q)
            S_RTS:       abort_c = !clk_fall && (cnt_q == CNT_W'(START_TO_CYC - 1));
            S_TX:        abort_c = !clk_fall && bit_to_c;
            S_LACK: begin
                if (clk_fall) begin
                    abort_c      = data_s;
                    abort_code_c = 2'b10;
                end else begin
                    abort_c = bit_to_c;
                end
            end
            S_WAIT_IDLE: abort_c = !(clk_s && data_s) && bit_to_c;
            S_RESP: begin
                if (rx_valid) begin
                    abort_c      = !(rx_ack_c || (rx_resend_c && (retry_q < RETRY_W'(MAX_RETRY))));
                    abort_code_c = 2'b11;
                end else begin
                    abort_c = (cnt_q == CNT_W'(RESP_TO_CYC - 1));
                end
            end
`ifdef PS2_BAT_WAIT_EN
            S_BAT: begin
                if (rx_valid) begin
                    abort_c      = rx_err || (rx_byte != BYTE_BAT_OK);
                    abort_code_c = 2'b11;
                end else begin
                    abort_c = (cnt_q == CNT_W'(BAT_TO_CYC - 1));
                end
            end
`endif
            default: abort_c = 1'b0;
        endcase
    end

    // Main sequencer; all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            retry_q     <= '0;
            op_q        <= '0;
            arg_q       <= '0;
            has_arg_q   <= 1'b0;
            arg_phase_q <= 1'b0;
            cur_q       <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            rx_owned_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (abort_c) begin
                state_q    <= S_ERR;
                err_q      <= 1'b1;
                err_code_q <= abort_code_c;
                clk_oe_q   <= 1'b0;
                data_oe_q  <= 1'b0;
                rx_owned_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cmd_valid && cmd_ready_q) begin
                            op_q        <= cmd_op;
                            arg_q       <= cmd_arg;
                            has_arg_q   <= cmd_has_arg;
                            cur_q       <= cmd_op;
                            arg_phase_q <= 1'b0;
                            retry_q     <= '0;
                            err_code_q  <= 2'b00;
                            cmd_ready_q <= 1'b0;
                            clk_oe_q    <= 1'b1;
                            data_oe_q   <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        // Start bit goes down one cycle before the clock is released.
                        if (cnt_q == CNT_W'(INHIBIT_CYC - 2)) begin
                            data_oe_q <= 1'b1;
                        end
                        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
                            clk_oe_q   <= 1'b0;
                            data_oe_q  <= 1'b1;
                            rx_owned_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= S_RTS;
                        end
                    end
                    S_RTS: begin
                        if (clk_fall) begin
                            data_oe_q <= ~cur_q[0];
                            bit_q     <= 4'd1;
                            cnt_q     <= '0;
                            state_q   <= S_TX;
                        end
                    end
                    S_TX: begin
                        // bit_q counts edges already seen; this edge is number bit_q+1.
                        if (clk_fall) begin
                            bit_q <= bit_q + 4'd1;
                            cnt_q <= '0;
                            if (bit_q < 4'd8) begin
                                data_oe_q <= ~cur_q[bit_q[2:0]];
                            end else if (bit_q == 4'd8) begin
                                data_oe_q <= ~(~^cur_q);
                            end else begin
                                data_oe_q <= 1'b0;
                                state_q   <= S_LACK;
                            end
                        end
                    end
                    S_LACK: begin
                        if (clk_fall) begin
                            cnt_q   <= '0;
                            state_q <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (clk_s && data_s) begin
                            cnt_q   <= '0;
                            state_q <= S_RESP;
                        end
                    end
                    S_RESP: begin
                        if (rx_valid) begin
                            if (rx_ack_c) begin
                                // A phase flag rather than comparing cur_q with op_q keeps an
                                // argument equal to its opcode from being resent forever.
                                if (has_arg_q && !arg_phase_q) begin
                                    cur_q       <= arg_q;
                                    arg_phase_q <= 1'b1;
                                    retry_q     <= '0;
                                    clk_oe_q    <= 1'b1;
                                    data_oe_q   <= 1'b0;
                                    rx_owned_q  <= 1'b0;
                                    cnt_q       <= '0;
                                    state_q     <= S_INHIBIT;
                                end
`ifdef PS2_BAT_WAIT_EN
                                else if (op_q == BYTE_RESET) begin
                                    cnt_q   <= '0;
                                    state_q <= S_BAT;
                                end
`endif
                                else begin
                                    done_q     <= 1'b1;
                                    rx_owned_q <= 1'b0;
                                    state_q    <= S_DONE;
                                end
                            end else begin
                                // Resend with retries left (exhaustion is an abort).
                                retry_q    <= retry_q + RETRY_W'(1);
                                clk_oe_q   <= 1'b1;
                                data_oe_q  <= 1'b0;
                                rx_owned_q <= 1'b0;
                                cnt_q      <= '0;
                                state_q    <= S_INHIBIT;
                            end
                        end
                    end
`ifdef PS2_BAT_WAIT_EN
                    S_BAT: begin
                        if (rx_valid) begin
                            done_q     <= 1'b1;
                            rx_owned_q <= 1'b0;
                            state_q    <= S_DONE;
                        end
                    end
`endif
                    S_DONE, S_ERR: begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                    default: begin
                        clk_oe_q    <= 1'b0;
                        data_oe_q   <= 1'b0;
                        rx_owned_q  <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign cmd_ready   = cmd_ready_q;
    assign rx_owned    = rx_owned_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule
